// File: rtl/wam_ctl.sv
// Whac-a-mole game-flow sequencer: round state, countdown timing, difficulty
// level and button edge detection for the raw lft/rgt/pse inputs.
module wam_ctl #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int ROUND_SEC = 60,
  parameter int CD_SEC    = 3,
  parameter int LVL_MAX   = 3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       lft,
  input  logic       rgt,
  input  logic       pse,
  output logic       run,
  output logic       score_clr,
  output logic [1:0] level,
  output logic [7:0] secs,
  output logic [2:0] state,
  output logic       over
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CDOWN = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [7:0]    ROUND_INIT = 8'(ROUND_SEC);
  localparam logic [7:0]    CD_INIT    = 8'(CD_SEC);
  localparam logic [1:0]    LVL_TOP    = 2'(LVL_MAX);

  logic [2:0]    btnSync1_q, btnSync2_q, btnHist_q;
  logic [1:0]    warmUp_q;
  logic [2:0]    btnEdge;
  logic          lftEdge, rgtEdge, pseEdge;

  state_e        state_q, state_d;
  logic [PW-1:0] preCnt_q, preCnt_d;
  logic [7:0]    secs_q, secs_d;
  logic [1:0]    level_q, level_d;
  logic          scoreClr_q, scoreClr_d;
  logic          run_q, over_q;
  logic          tick;

  // History stays high until the synchroniser holds real samples, so a button
  // held through reset only counts once it is released and pressed again.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      btnSync1_q <= 3'b000;
      btnSync2_q <= 3'b000;
      btnHist_q  <= 3'b111;
      warmUp_q   <= 2'd0;
    end else begin
      btnSync1_q <= {pse, rgt, lft};
      btnSync2_q <= btnSync1_q;
      btnHist_q  <= (warmUp_q == 2'd2) ? btnSync2_q : 3'b111;
      if (warmUp_q != 2'd2) begin
        warmUp_q <= warmUp_q + 2'd1;
      end
    end
  end

  assign btnEdge = btnSync2_q & ~btnHist_q;
  assign lftEdge = btnEdge[0];
  assign rgtEdge = btnEdge[1];
  assign pseEdge = btnEdge[2];

  always_comb begin
    state_d    = state_q;
    preCnt_d   = preCnt_q;
    secs_d     = secs_q;
    level_d    = level_q;
    scoreClr_d = 1'b0;
    tick       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        preCnt_d = '0;
        secs_d   = 8'd0;
        if (lftEdge && !rgtEdge && level_q != 2'd0) begin
          level_d = level_q - 2'd1;
        end else if (rgtEdge && !lftEdge && level_q < LVL_TOP) begin
          level_d = level_q + 2'd1;
        end
        if (pseEdge) begin
          state_d    = ST_CDOWN;
          secs_d     = CD_INIT;
          scoreClr_d = 1'b1;
        end
      end
      ST_CDOWN: begin
        tick     = (preCnt_q == PRE_LAST);
        preCnt_d = tick ? '0 : preCnt_q + PW'(1);
        if (tick) begin
          if (secs_q == 8'd1) begin
            state_d = ST_PLAY;
            secs_d  = ROUND_INIT;
          end else if (secs_q != 8'd0) begin
            secs_d = secs_q - 8'd1;
          end
        end
      end
      ST_PLAY: begin
        tick     = (preCnt_q == PRE_LAST);
        preCnt_d = tick ? '0 : preCnt_q + PW'(1);
        // The final tick outranks a simultaneous pause request.
        if (tick && secs_q == 8'd1) begin
          state_d = ST_OVER;
          secs_d  = 8'd0;
        end else begin
          if (tick && secs_q != 8'd0) begin
            secs_d = secs_q - 8'd1;
          end
          if (pseEdge) begin
            state_d = ST_PAUSE;
          end
        end
      end
      ST_PAUSE: begin
        if (pseEdge) begin
          state_d = ST_PLAY;
        end
      end
      ST_OVER: begin
        preCnt_d = '0;
        secs_d   = 8'd0;
        if (pseEdge) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        preCnt_d = '0;
        secs_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= ST_IDLE;
      preCnt_q   <= '0;
      secs_q     <= 8'd0;
      level_q    <= 2'd0;
      scoreClr_q <= 1'b0;
      run_q      <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      preCnt_q   <= preCnt_d;
      secs_q     <= secs_d;
      level_q    <= level_d;
      scoreClr_q <= scoreClr_d;
      run_q      <= (state_d == ST_PLAY);
      over_q     <= (state_d == ST_OVER);
    end
  end

  assign run       = run_q;
  assign score_clr = scoreClr_q;
  assign level     = level_q;
  assign secs      = secs_q;
  assign state     = state_q;
  assign over      = over_q;

endmodule

// File: tb/tb_wam_ctl.sv
// Bench for wam_ctl: level table, directed round/pause/collision/reset
// sequences, then random button activity against a behavioural game model.
module tb_wam_ctl;

  localparam int TICK_DIV  = 4;
  localparam int ROUND_SEC = 5;
  localparam int CD_SEC    = 2;
  localparam int LVL_MAX   = 3;

  logic       clk = 1'b0;
  logic       clr;
  logic       lft, rgt, pse;
  logic       run, scoreClr, over;
  logic [1:0] level;
  logic [7:0] secs;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;
  bit modelOn  = 1'b0;

  int mState, mLevel, mSecs, mPre;
  bit mClrPulse;
  bit histL[$], histR[$], histP[$];

  typedef struct {
    bit l;
    bit r;
    bit p;
    int expLevel;
  } vec_t;

  vec_t vecs[11];

  wam_ctl #(
    .TICK_DIV (TICK_DIV),
    .ROUND_SEC(ROUND_SEC),
    .CD_SEC   (CD_SEC),
    .LVL_MAX  (LVL_MAX)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .lft      (lft),
    .rgt      (rgt),
    .pse      (pse),
    .run      (run),
    .score_clr(scoreClr),
    .level    (level),
    .secs     (secs),
    .state    (state),
    .over     (over)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pre-reset history counts as "pressed", so a held button needs a release first.
  function automatic void modelReset();
    mState = 0; mLevel = 0; mSecs = 0; mPre = 0; mClrPulse = 1'b0;
    histL.delete(); histR.delete(); histP.delete();
    for (int i = 0; i < 3; i++) begin
      histL.push_back(1'b1); histR.push_back(1'b1); histP.push_back(1'b1);
    end
  endfunction

  // A press registers two edges after it is first sampled high.
  function automatic void modelStep(input bit l, input bit r, input bit p);
    bit evL, evR, evP, tick;
    evL = histL[1] && !histL[0];
    evR = histR[1] && !histR[0];
    evP = histP[1] && !histP[0];
    histL.push_back(l); void'(histL.pop_front());
    histR.push_back(r); void'(histR.pop_front());
    histP.push_back(p); void'(histP.pop_front());
    mClrPulse = 1'b0;
    tick = (mState == 1 || mState == 2) && (mPre == TICK_DIV - 1);
    if (mState == 1 || mState == 2) mPre = tick ? 0 : mPre + 1;
    else if (mState != 3) mPre = 0;
    case (mState)
      0: begin
        if (evR && !evL && mLevel < LVL_MAX) mLevel = mLevel + 1;
        if (evL && !evR && mLevel > 0) mLevel = mLevel - 1;
        if (evP) begin mState = 1; mSecs = CD_SEC; mClrPulse = 1'b1; end
      end
      1: if (tick) begin
        if (mSecs == 1) begin mState = 2; mSecs = ROUND_SEC; end
        else if (mSecs > 0) mSecs = mSecs - 1;
      end
      2: begin
        if (tick && mSecs == 1) begin mState = 4; mSecs = 0; end
        else begin
          if (tick && mSecs > 0) mSecs = mSecs - 1;
          if (evP) mState = 3;
        end
      end
      3: if (evP) mState = 2;
      4: begin mSecs = 0; if (evP) mState = 0; end
      default: mState = 0;
    endcase
  endfunction

  always @(posedge clk or negedge clr) begin
    if (!clr) modelReset();
    else modelStep(lft, rgt, pse);
  end

  always @(negedge clk) begin
    if (modelOn) begin
      checkOutput("model state", state, mState);
      checkOutput("model level", level, mLevel);
      checkOutput("model secs", secs, mSecs);
      checkOutput("model run", run, (mState == 2));
      checkOutput("model over", over, (mState == 4));
      checkOutput("model score_clr", scoreClr, mClrPulse);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Single-cycle press; returns just after the edge where the press takes effect.
  task automatic applyStimulus(input bit l, input bit r, input bit p);
    lft = l; rgt = r; pse = p;
    step(1);
    lft = 1'b0; rgt = 1'b0; pse = 1'b0;
    step(2);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 2};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 3};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 3};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 3};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 2};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1};

    clr = 1'b1; lft = 1'b0; rgt = 1'b0; pse = 1'b0;
    #2 clr = 1'b0;
    #1;
    checkOutput("reset state", state, 0);
    checkOutput("reset level", level, 0);
    checkOutput("reset secs", secs, 0);
    checkOutput("reset run", run, 0);
    checkOutput("reset over", over, 0);
    checkOutput("reset score_clr", scoreClr, 0);
    modelOn = 1'b1;
    step(3);
    #3 clr = 1'b1;
    step(4);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].l, vecs[i].r, vecs[i].p);
      checkOutput($sformatf("level vec%0d", i), level, vecs[i].expLevel);
      checkOutput($sformatf("level vec%0d state", i), state, 0);
    end

    rgt = 1'b1;
    step(100);
    rgt = 1'b0;
    step(3);
    checkOutput("held rgt single step", level, 2);

    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("round cdown state", state, 1);
    checkOutput("round score_clr", scoreClr, 1);
    checkOutput("round cdown secs", secs, CD_SEC);
    step(1);
    checkOutput("round score_clr drop", scoreClr, 0);
    step(7);
    checkOutput("round play state", state, 2);
    checkOutput("round play secs", secs, ROUND_SEC);
    checkOutput("round play run", run, 1);
    step(19);
    checkOutput("round last second", secs, 1);
    step(1);
    checkOutput("round over state", state, 4);
    checkOutput("round over secs", secs, 0);
    checkOutput("round over flag", over, 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("round back idle", state, 0);
    checkOutput("round level kept", level, 2);

    applyStimulus(1'b0, 1'b0, 1'b1);
    step(7);
    pse = 1'b1;
    step(1);
    checkOutput("pause play entry", state, 2);
    pse = 1'b0;
    step(2);
    checkOutput("pause state", state, 3);
    checkOutput("pause run", run, 0);
    step(50);
    checkOutput("pause held state", state, 3);
    checkOutput("pause held secs", secs, ROUND_SEC);
    checkOutput("pause held run", run, 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("resume state", state, 2);
    step(1);
    checkOutput("resume secs +1", secs, ROUND_SEC);
    step(1);
    checkOutput("resume tick +2", secs, ROUND_SEC - 1);
    step(12);
    checkOutput("collide last second", secs, 1);
    step(1);
    pse = 1'b1;
    step(1);
    pse = 1'b0;
    step(1);
    checkOutput("collide pre state", state, 2);
    step(1);
    checkOutput("collide over wins", state, 4);
    checkOutput("collide over flag", over, 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("collide back idle", state, 0);

    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("cdown ignores pse", state, 1);
    checkOutput("cdown secs", secs, CD_SEC);
    step(5);
    checkOutput("cdown to play", state, 2);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("play ignores rgt", level, 2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("play ignores lft", level, 2);
    #2 clr = 1'b0;
    #1;
    checkOutput("async reset state", state, 0);
    checkOutput("async reset run", run, 0);
    checkOutput("async reset secs", secs, 0);
    checkOutput("async reset level", level, 0);
    step(2);
    #3 clr = 1'b1;
    step(4);

    pse = 1'b1;
    step(1);
    #2 clr = 1'b0;
    step(2);
    #2 clr = 1'b1;
    step(10);
    checkOutput("held pse through reset", state, 0);
    pse = 1'b0;
    step(4);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("repress after reset", state, 1);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) lft = ~lft;
      if ($urandom_range(0, 15) == 0) rgt = ~rgt;
      if ($urandom_range(0, 15) == 0) pse = ~pse;
      if ($urandom_range(0, 599) == 0) begin
        #2 clr = 1'b0;
        step(2);
        #3 clr = 1'b1;
      end
      step(1);
    end

    modelOn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
